// File: rtl/present_key_schedule.sv
// present_key_schedule: iterative PRESENT key schedule. It loads a master key
//   and then streams round keys K1..K32, one per accepted rk_valid/rk_ready handshake.
// Latency: K1 is valid 1 cycle after key_load is sampled in IDLE. Each accept
//   presents the next key 1 cycle later.
// Backpressure: while rk_valid && !rk_ready, rk_out, rk_idx and rk_last hold. No key is dropped.
// Build option: define PRESENT_KEY128_EN to select PRESENT-128 (KW=128).
//   Otherwise the build is PRESENT-80 (KW=80).
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   key_load     load strobe, sampled only in IDLE
//   key_in       master key [0:KW-1], key_in[0] = k[KW-1]
//   busy         high while streaming (RUN)
//   rk_valid     rk_out carries a round key
//   rk_ready     consumer accepts rk_out
//   rk_out       round key [0:63] = k[KW-1..KW-64]
//   rk_idx       index 1..32 of rk_out, 0 in IDLE
//   rk_last      high with K32
module present_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_load,
`ifdef PRESENT_KEY128_EN
  input  logic [0:127] key_in,
`else
  input  logic [0:79]  key_in,
`endif
  output logic        busy,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [0:63] rk_out,
  output logic [5:0]  rk_idx,
  output logic        rk_last
);

`ifdef PRESENT_KEY128_EN
  localparam int KW = 128;
`else
  localparam int KW = 80;
`endif

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   key_q, key_d;
  logic [5:0]      idx_q, idx_d;
  logic [KW-1:0]   key_rot;
  logic [KW-1:0]   key_upd;
  logic [4:0]      rnd_c;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  // The round counter for the update is the index of the key just consumed (1..31).
  assign rnd_c   = idx_q[4:0];
  // Rotate left by 61: the low KW-61 bits move to the top.
  assign key_rot = {key_q[KW-62:0], key_q[KW-1:KW-61]};

  always_comb begin
    key_upd = key_rot;
    key_upd[KW-1 -: 4] = sbox(key_rot[KW-1 -: 4]);
`ifdef PRESENT_KEY128_EN
    key_upd[KW-5 -: 4] = sbox(key_rot[KW-5 -: 4]);
    key_upd[66:62]     = key_rot[66:62] ^ rnd_c;
`else
    key_upd[19:15]     = key_rot[19:15] ^ rnd_c;
`endif
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (key_load) begin
          key_d   = key_in;
          idx_d   = 6'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (idx_q == 6'd32) begin
            // The final key has been consumed. The register keeps its last contents.
            idx_d   = 6'd0;
            state_d = IDLE;
          end else begin
            key_d = key_upd;
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign rk_valid = busy;
  assign rk_out   = key_q[KW-1 -: 64];
  assign rk_idx   = idx_q;
  assign rk_last  = busy && (idx_q == 6'd32);

endmodule

// File: tb/tb_present_key_schedule.sv
// Testbench for present_key_schedule.
// The bench uses randomized readiness and a scoreboard fed from a plain-arithmetic key-schedule model.
// Known-answer values come from the PRESENT reference (zero key, zero plaintext).
module tb_present_key_schedule;

`ifdef PRESENT_KEY128_EN
  localparam int KW = 128;
`else
  localparam int KW = 80;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_load;
  logic [0:KW-1] key_in;
  logic          busy, rk_valid, rk_ready, rk_last;
  logic [0:63]   rk_out;
  logic [5:0]    rk_idx;

  present_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_out(rk_out), .rk_idx(rk_idx), .rk_last(rk_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [63:0] key;
  } exp_t;

  exp_t        exp_q[$];
  logic [3:0]  sbox_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [63:0] caps [1:32];
  int          checks = 0;
  int          failures = 0;
  bit          ready_rand = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: the key register is an integer of KW bits.
  // Each step rotates it, substitutes the top nibble(s) and adds the counter.
  task automatic push_expected(input logic [KW-1:0] k0);
    logic [KW-1:0] k;
    exp_t e;
    k = k0;
    for (int i = 1; i <= 32; i++) begin
      e.idx = 6'(i);
      e.key = k[KW-1 -: 64];
      exp_q.push_back(e);
      k = (k << 61) | (k >> (KW - 61));
      k[KW-1 -: 4] = sbox_t[k[KW-1 -: 4]];
`ifdef PRESENT_KEY128_EN
      k[KW-5 -: 4] = sbox_t[k[KW-5 -: 4]];
      k = k ^ (KW'(i) << 62);
`else
      k = k ^ (KW'(i) << 15);
`endif
    end
  endtask

  // The caller is positioned just after a rising edge with the DUT idle.
  task automatic load_key(input logic [KW-1:0] k);
    key_in   = k;
    key_load = 1'b1;
    push_expected(k);
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic wait_idx(input logic [5:0] target);
    int n;
    n = 0;
    while (rk_idx != target && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (rk_idx != target) chk("wait_idx_timeout", {122'd0, rk_idx}, {122'd0, target});
  endtask

  // Encrypt using the round keys captured from the DUT's last stream.
  function automatic logic [63:0] present_enc(input logic [63:0] pt);
    logic [63:0] s, p;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ caps[r];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox_t[s[4*n +: 4]];
      p = '0;
      for (int j = 0; j < 64; j++) p[(j == 63) ? 63 : (j * 16) % 63] = s[j];
      s = p;
    end
    return s ^ caps[32];
  endfunction

  // Drive readiness away from the edge: it is either held high or randomized.
  initial begin
    rk_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rk_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: sample on the falling edge and pop one expectation per accepted key.
  bit          stall_prev = 0;
  bit          idle_chk = 0;
  int          acc_cnt = 0;
  logic [63:0] prev_key;
  logic [5:0]  prev_idx;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev = 0;
      idle_chk   = 0;
      acc_cnt    = 0;
    end else begin
      if (idle_chk) begin
        chk("busy_drop_after_k32", {127'd0, busy}, 128'd0);
        idle_chk = 0;
      end
      if (rk_valid) begin
        if (stall_prev) begin
          chk("stall_rk_out", {64'd0, rk_out}, {64'd0, prev_key});
          chk("stall_rk_idx", {122'd0, rk_idx}, {122'd0, prev_idx});
        end
        if (rk_ready) begin
          stall_prev = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_key", {122'd0, rk_idx}, 128'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rk_out", {64'd0, rk_out}, {64'd0, e.key});
            chk("rk_idx", {122'd0, rk_idx}, {122'd0, e.idx});
            chk("rk_last", {127'd0, rk_last}, {127'd0, (e.idx == 6'd32)});
            if (e.idx >= 1 && e.idx <= 32) caps[e.idx] = rk_out;
            acc_cnt++;
            if (e.idx == 6'd32) begin
              chk("stream_len", 128'(acc_cnt), 128'd32);
              acc_cnt  = 0;
              idle_chk = 1;
            end
          end
        end else begin
          stall_prev = 1;
          prev_key   = rk_out;
          prev_idx   = rk_idx;
        end
      end else begin
        stall_prev = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    key_load = 1'b0;
    key_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_valid", {127'd0, rk_valid}, 128'd0);
    chk("rst_rk_out", {64'd0, rk_out}, 128'd0);
    chk("rst_rk_idx", {122'd0, rk_idx}, 128'd0);
    chk("rst_rk_last", {127'd0, rk_last}, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero key, consumer always ready.
    load_key('0);
    wait_idle();
    chk("k1_zero", {64'd0, caps[1]}, 128'd0);
`ifdef PRESENT_KEY128_EN
    chk("k2_zero", {64'd0, caps[2]}, {64'd0, 64'hCC00000000000000});
`else
    chk("k2_zero", {64'd0, caps[2]}, {64'd0, 64'hC000000000000000});
    chk("k32_zero", {64'd0, caps[32]}, {64'd0, 64'h6DAB31744F41D700});
`endif

    // Zero key with random backpressure.
    ready_rand = 1'b1;
    load_key('0);
    wait_idle();
    ready_rand = 1'b0;
    @(posedge clk); #1;
`ifndef PRESENT_KEY128_EN
    chk("k32_backpressure", {64'd0, caps[32]}, {64'd0, 64'h6DAB31744F41D700});
`endif

    // A load attempt while busy must be ignored.
    // A load in the first idle cycle must be accepted.
    load_key('0);
    wait_idx(6'd5);
    key_in   = '1;
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    wait_idle();
`ifndef PRESENT_KEY128_EN
    chk("k32_after_busy_load", {64'd0, caps[32]}, {64'd0, 64'h6DAB31744F41D700});
`endif
    load_key('1);
    wait_idle();
    chk("k1_all_f", {64'd0, caps[1]}, {64'd0, 64'hFFFFFFFFFFFFFFFF});

    // Back-to-back zero-key loads, then a full encryption with the streamed keys.
    load_key('0);
    wait_idle();
    load_key('0);
    wait_idle();
`ifndef PRESENT_KEY128_EN
    chk("ciphertext_zero", {64'd0, present_enc(64'd0)}, {64'd0, 64'h5579C1387B228445});
`endif

    // A random key streams under random backpressure.
    ready_rand = 1'b1;
    load_key({$urandom, $urandom, $urandom, $urandom});
    wait_idle();
    ready_rand = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a stream.
    load_key('0);
    wait_idx(6'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {127'd0, busy}, 128'd0);
    chk("midrst_valid", {127'd0, rk_valid}, 128'd0);
    chk("midrst_rk_idx", {122'd0, rk_idx}, 128'd0);
    chk("midrst_rk_out", {64'd0, rk_out}, 128'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", {127'd0, rk_valid}, 128'd0);
    end

    // After the reset, a fresh stream must run normally.
    load_key('0);
    wait_idle();
    @(posedge clk); #1;
    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
